pe_csc_loader: RTL
==================

PE_CSC_LOADER -- requirements
Module: pe_csc_loader

Interface
REQ-001 SHALL have parameter DATA_IN_WIDTH, default 8: width of every stream word (header, length, data).
REQ-002 SHALL have parameter DATA_SPAD_DEPTH, default 16: data scratchpad entries. DATA_AW = clog2(DATA_SPAD_DEPTH).
REQ-003 SHALL have parameter ADDR_SPAD_DEPTH, default 8: column-pointer scratchpad entries. ADDR_AW = clog2(ADDR_SPAD_DEPTH).
REQ-004 SHALL use one clock; reset is synchronous and active-high. Ports are clk and rst.
REQ-005 clk  input  1  clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  stream word present. Driven from the PE data FIFO data_out_valid.
REQ-008 in_data  input  DATA_IN_WIDTH  stream word.
REQ-009 in_ready  output  1  tied 1; the block never back-pressures.
REQ-010 data_spad_we  output  1  data scratchpad write strobe.
REQ-011 data_spad_waddr  output  DATA_AW  data write address.
REQ-012 data_spad_wdata  output  DATA_IN_WIDTH  data write value.
REQ-013 addr_spad_we  output  1  pointer scratchpad write strobe.
REQ-014 addr_spad_waddr  output  ADDR_AW  column index.
REQ-015 addr_spad_wdata  output  DATA_AW+1  cumulative end pointer.
REQ-016 busy  output  1  high while not in IDLE.
REQ-017 load_done  output  1  one-cycle pulse at the end of a segment.
REQ-018 overflow_err  output  1  sticky error flag.

Function
REQ-019 Segment format SHALL be:
- header C (column count)
- then for each column: length L, followed by L data words.
REQ-020 FSM states SHALL be IDLE, LEN and DATA. Any cycle with in_valid=0 SHALL hold all state and counters.
REQ-021 In IDLE, a valid word SHALL be taken as C.
- C=0: stay in IDLE and pulse load_done next cycle; no writes.
- C>0: col_idx=0, ptr=0, go to LEN.
REQ-022 In LEN with L=0:
- issue an addr write of (col_idx, ptr).
- last column: go to IDLE. Otherwise col_idx+1 and stay in LEN.
REQ-023 In LEN with L>0: data_left=L, go to DATA.
REQ-024 In DATA, each valid word SHALL:
- issue a data write of (ptr, word).
- ptr+1, data_left-1.
REQ-025 When data_left reaches 0, the same output cycle SHALL also carry an addr write of (col_idx, ptr+1). Then go to LEN, or to IDLE if this was the last column.
REQ-026 All outputs SHALL be registered, with latency exactly 1 cycle from the accepted word to its write strobe.
REQ-027 load_done SHALL pulse in the same cycle as the final addr write of the segment.
REQ-028 The next segment header MAY arrive on the cycle immediately after a segment's last word. Back-to-back segments need no idle gap.
REQ-029 When ptr=DATA_SPAD_DEPTH:
- data writes are suppressed.
- ptr saturates.
- overflow_err is set.
- the stream is still parsed to the segment end.
REQ-030 When col_idx>=ADDR_SPAD_DEPTH:
- addr writes are suppressed.
- overflow_err is set.
- parsing continues.
REQ-031 overflow_err SHALL clear only on rst, or on acceptance of a new header in IDLE.
REQ-032 Strobes not asserted in a cycle SHALL leave their address/data outputs holding their last values.

Reset
REQ-033 rst SHALL force:
- state=IDLE
- all counters to 0
- all strobes, busy, load_done and overflow_err to 0
- address/data outputs to 0.
REQ-034 rst mid-segment SHALL abandon the segment. The first valid word after rst deasserts is a header.

Structure
REQ-035 The FSM state encoding and stream-format constants SHALL live in the shared PE package.
REQ-036 The block SHALL be one flat module with no sub-modules. Downstream scratchpads and the upstream FIFO are instantiated by the PE top.

Verification
REQ-037 Scenario: stream 2,2,A,B,1,C with no gaps. Required response:
- data writes (0,A),(1,B),(2,C).
- addr writes (0,2),(1,3).
- load_done coincident with (1,3).
REQ-038 Scenario: stream 3,0,1,D,0. Required response:
- addr writes (0,0),(1,1),(2,1).
- data write (0,D).
- load_done once.
REQ-039 Scenario: header 0, then immediately 1,1,E. Required response:
- load_done pulses twice.
- second segment writes data (0,E) and addr (0,1).
REQ-040 Scenario: stream 1,18 followed by 18 words (depth 16). Required response:
- 16 data writes.
- overflow_err=1.
- addr write (0,16).
- load_done.
- Next header clears overflow_err.
REQ-041 Scenario: stream 2,3,X,Y, then rst for one cycle, then 1,1,Z. Required response:
- no writes after rst.
- data (0,Z) and addr (0,1) afterwards.
REQ-042 Scenario: scenario REQ-037 with random in_valid gaps. Required response: identical write sequence to REQ-037, each write 1 cycle after its accepted word.

Source files
------------

// File: rtl/pe_csc_loader_pkg.sv
// rtl/pe_csc_loader_pkg.sv - shared PE package: CSC loader FSM encoding and stream-format constants
package pe_csc_loader_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LEN  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  // A zero in the header or length slot marks an empty segment or column
  localparam int EMPTY_COUNT = 0;

endpackage

// File: rtl/pe_csc_loader.sv
// rtl/pe_csc_loader.sv - parses a CSC segment stream into data and column-pointer scratchpad writes
module pe_csc_loader
  import pe_csc_loader_pkg::*;
#(
  parameter int DATA_IN_WIDTH   = 8,
  parameter int DATA_SPAD_DEPTH = 16,
  parameter int ADDR_SPAD_DEPTH = 8,
  localparam int DATA_AW = $clog2(DATA_SPAD_DEPTH),
  localparam int ADDR_AW = $clog2(ADDR_SPAD_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_IN_WIDTH-1:0] in_data,
  output logic                     in_ready,
  output logic                     data_spad_we,
  output logic [DATA_AW-1:0]       data_spad_waddr,
  output logic [DATA_IN_WIDTH-1:0] data_spad_wdata,
  output logic                     addr_spad_we,
  output logic [ADDR_AW-1:0]       addr_spad_waddr,
  output logic [DATA_AW:0]         addr_spad_wdata,
  output logic                     busy,
  output logic                     load_done,
  output logic                     overflow_err
);

  localparam logic [DATA_AW:0]         PTR_FULL  = (DATA_AW+1)'(DATA_SPAD_DEPTH);
  localparam logic [DATA_IN_WIDTH:0]   COL_LIMIT = (DATA_IN_WIDTH+1)'(ADDR_SPAD_DEPTH);
  localparam logic [DATA_IN_WIDTH-1:0] EMPTY     = DATA_IN_WIDTH'(EMPTY_COUNT);

  logic [1:0]               state;
  logic [DATA_IN_WIDTH-1:0] num_cols;
  logic [DATA_IN_WIDTH-1:0] col_idx;
  logic [DATA_IN_WIDTH-1:0] data_left;
  logic [DATA_AW:0]         ptr;

  logic             ptr_full;
  logic [DATA_AW:0] ptr_inc;
  logic [DATA_AW:0] end_ptr;
  logic             col_in_range;
  logic             last_col;
  logic             col_end;

  // col_end marks the accepted word that closes a column: a zero length, or its last data word
  always_comb begin
    ptr_full     = (ptr == PTR_FULL);
    ptr_inc      = ptr_full ? ptr : ptr + 1'b1;
    end_ptr      = (state == ST_DATA) ? ptr_inc : ptr;
    col_in_range = ({1'b0, col_idx} < COL_LIMIT);
    last_col     = (col_idx == num_cols - 1'b1);
    col_end      = in_valid &&
                   (((state == ST_LEN) && (in_data == EMPTY)) ||
                    ((state == ST_DATA) && (data_left == DATA_IN_WIDTH'(1))));
  end

  assign in_ready = 1'b1;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      num_cols        <= '0;
      col_idx         <= '0;
      data_left       <= '0;
      ptr             <= '0;
      data_spad_we    <= 1'b0;
      data_spad_waddr <= '0;
      data_spad_wdata <= '0;
      addr_spad_we    <= 1'b0;
      addr_spad_waddr <= '0;
      addr_spad_wdata <= '0;
      load_done       <= 1'b0;
      overflow_err    <= 1'b0;
    end else begin
      data_spad_we <= 1'b0;
      addr_spad_we <= 1'b0;
      load_done    <= 1'b0;
      if (in_valid) begin
        case (state)
          ST_IDLE: begin
            overflow_err <= 1'b0;
            if (in_data == EMPTY) begin
              load_done <= 1'b1;
            end else begin
              num_cols <= in_data;
              col_idx  <= '0;
              ptr      <= '0;
              state    <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (in_data != EMPTY) begin
              data_left <= in_data;
              state     <= ST_DATA;
            end
          end
          ST_DATA: begin
            data_left <= data_left - 1'b1;
            ptr       <= ptr_inc;
            if (!ptr_full) begin
              data_spad_we    <= 1'b1;
              data_spad_waddr <= ptr[DATA_AW-1:0];
              data_spad_wdata <= in_data;
            end else begin
              overflow_err <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase

        // Column close overrides the state chosen above
        if (col_end) begin
          if (col_in_range) begin
            addr_spad_we    <= 1'b1;
            addr_spad_waddr <= col_idx[ADDR_AW-1:0];
            addr_spad_wdata <= end_ptr;
          end else begin
            overflow_err <= 1'b1;
          end
          if (last_col) begin
            state     <= ST_IDLE;
            load_done <= 1'b1;
          end else begin
            col_idx <= col_idx + 1'b1;
            state   <= ST_LEN;
          end
        end
      end
    end
  end

endmodule
